dlatch_write_sequencer: RTL and testbench

//   Synchronous write sequencer that sits directly upstream of a bank of

---
 rtl/dlatch_write_sequencer.sv | 129 ++++++++++++
 tb/tb_dlatch_write_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlatch_write_sequencer.sv
// dlatch_write_sequencer
//   Drives the D and En inputs of a bank of D latches. A word is accepted
//   over a valid/ready handshake. It is then presented on latch_d, and
//   latch_en is pulsed with setup and hold margins counted in clock cycles.
//   Finally the latch Q outputs are read back and compared with latch_d.
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only in IDLE. Outside IDLE,
//   req_valid and req_data are ignored.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request offered
//   req_ready  sequencer idle, request can be accepted
//   req_data   word to write
//   latch_d    latch bank D inputs
//   latch_en   latch bank En input, decoded from the one-hot state
//   latch_q    latch bank Q outputs (readback)
//   done       one-cycle pulse when a sequence completes
//   err        pulses with done when latch_q != latch_d
//   fsm_state  one-hot state register, for observation
module dlatch_write_sequencer #(
    parameter int WIDTH = 8,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] latch_d,
    output logic             latch_en,
    input  logic [WIDTH-1:0] latch_q,
    output logic             done,
    output logic             err,
    output logic [4:0]       fsm_state
);

    localparam int MAXP = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                          : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW   = $clog2(MAXP + 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SETUP = 5'b00010,
        S_PULSE = 5'b00100,
        S_HOLD  = 5'b01000,
        S_CHECK = 5'b10000
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [WIDTH-1:0]  d_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            latch_d <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            latch_d <= d_next;
        end
    end

    // Each phase loads cnt with its length minus one on entry. The phase
    // ends in the cycle where cnt reads zero, so a length of 1 gives a
    // single-cycle phase.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        d_next     = latch_d;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    d_next     = req_data;
                    cnt_next   = CW'(SETUP - 1);
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    cnt_next   = CW'(PULSE - 1);
                    state_next = S_PULSE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    cnt_next   = CW'(HOLD - 1);
                    state_next = S_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_next = S_CHECK;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_CHECK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are single-bit decodes of the one-hot register. This keeps
    // latch_en free of decode glitches, and reset clears it at once.
    assign req_ready = state[0];
    assign latch_en  = state[2];
    assign done      = state[4];
    // The latch outputs have settled by CHECK, so they are compared only
    // there.
    assign err       = state[4] & (latch_q != latch_d);
    assign fsm_state = state;

endmodule

// File: tb/tb_dlatch_write_sequencer.sv
module tb_dlatch_write_sequencer;

  localparam int W  = 8;
  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int T  = S + P + H;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // DUT A (defaults)
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] latch_d;
  logic         latch_en;
  logic [W-1:0] latch_q;
  logic         done;
  logic         err;
  logic [4:0]   fsm_state;

  // DUT B (SETUP=3, PULSE=1, HOLD=4)
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [W-1:0] b_data = '0;
  logic [W-1:0] b_d;
  logic         b_en;
  logic [W-1:0] b_q;
  logic         b_done;
  logic         b_err;
  logic [4:0]   b_state;

  dlatch_write_sequencer #(.WIDTH(W), .SETUP(S), .PULSE(P), .HOLD(H)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .latch_d(latch_d), .latch_en(latch_en),
    .latch_q(latch_q), .done(done), .err(err), .fsm_state(fsm_state)
  );

  dlatch_write_sequencer #(.WIDTH(W), .SETUP(3), .PULSE(1), .HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_data(b_data), .latch_d(b_d), .latch_en(b_en),
    .latch_q(b_q), .done(b_done), .err(b_err), .fsm_state(b_state)
  );

  // behavioural latch banks: transparent while En is high, optional stuck-at-0 bits
  logic [W-1:0] lat_a = '0;
  logic [W-1:0] lat_b = '0;
  logic [W-1:0] stuck = '0;
  always @(latch_en or latch_d) if (latch_en) lat_a = latch_d;
  always @(b_en or b_d) if (b_en) lat_b = b_d;
  assign latch_q = lat_a & ~stuck;
  assign b_q     = lat_b;

  // counters and check helper
  int total = 0;
  int bad = 0;
  function automatic void chk(string nm, int act, int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // scoreboard: {expected err, expected word}
  logic [W:0] exp_q[$];
  int acc_count = 0;
  int acc_cyc = 0;
  int prev_acc_cyc = 0;
  int done_count = 0;

  // accept watcher: handshake seen at negedge transfers on the next rising edge
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      exp_q.push_back({((req_data & ~stuck) != req_data), req_data});
      prev_acc_cyc = acc_cyc;
      acc_cyc = cyc + 1;
      acc_count = acc_count + 1;
    end
  end

  // monitor: elapsed = rising edges since the accept edge
  logic         busy = 1'b0;
  int           elapsed = 0;
  int           en_cnt = 0;
  int           first_en = -1;
  logic         seen_done = 1'b0;
  logic [W-1:0] cur_word = '0;
  logic [W:0]   e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      exp_q.delete();
    end else begin
      if (busy) begin
        elapsed = elapsed + 1;
        chk("d_stable", latch_d, cur_word);
        if (latch_en) begin
          en_cnt = en_cnt + 1;
          if (first_en < 0) first_en = elapsed;
        end
        if (elapsed <= T) chk("ready_low", req_ready, 0);
        if (done) begin
          seen_done = 1'b1;
          done_count = done_count + 1;
          chk("done_time", elapsed, T);
          chk("en_cycles", en_cnt, P);
          chk("en_start", first_en, S);
          if (exp_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("word", latch_d, e[W-1:0]);
            chk("err", err, e[W]);
          end
        end else begin
          chk("err_no_done", err, 0);
        end
        if (elapsed == T + 1) begin
          chk("done_seen", seen_done, 1);
          chk("done_one_cycle", done, 0);
          chk("ready_back", req_ready, 1);
          busy = 1'b0;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_en", latch_en, 0);
      end
      if (!busy && req_valid && req_ready) begin
        busy = 1'b1;
        elapsed = 0;
        en_cnt = 0;
        first_en = -1;
        seen_done = 1'b0;
        cur_word = req_data;
        elapsed = -1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] mask);
    int t;
    @(posedge clk); #1;
    stuck = mask;
    req_valid = 1'b1;
    req_data = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 100);
    if (t >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data = W'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 100);
    if (t >= 100) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_en();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!latch_en && t < 100);
    if (t >= 100) chk("en_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic exp_en_t[6]   = '{0, 1, 1, 0, 0, 0};
  logic exp_done_t[6] = '{0, 0, 0, 0, 1, 0};
  logic exp_rdy_t[6]  = '{0, 0, 0, 0, 0, 1};

  initial begin
    int base;
    int t;
    // test 1: reset state, then accept on the first edge after release
    req_valid = 1'b1;
    req_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_d", latch_d, 0);
    chk("rst_en", latch_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      chk("t1_d", latch_d, 8'hA5);
      chk("t1_en", latch_en, exp_en_t[k]);
      chk("t1_done", done, exp_done_t[k]);
      chk("t1_err", err, 0);
      chk("t1_ready", req_ready, exp_rdy_t[k]);
    end

    // test 2: stuck bit0, write 01 -> err
    send(8'h01, 8'h01);
    wait_done();
    chk("t2_err_cleared", err, 0);
    stuck = '0;

    // test 3: request during PULSE is ignored
    base = acc_count;
    send(8'hA5, 8'h00);
    wait_en();
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data = 8'hFF;
    @(negedge clk);
    chk("t3_ready", req_ready, 0);
    chk("t3_d", latch_d, 8'hA5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("t3_no_second", acc_count, base + 1);

    // test 4: asynchronous reset mid-PULSE
    send(8'h3C, 8'h00);
    wait_en();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_en", latch_en, 0);
    chk("t4_d", latch_d, 0);
    chk("t4_done", done, 0);
    chk("t4_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ready_rel", req_ready, 1);
    chk("t4_no_done", done, 0);

    // test 5: back-to-back with valid held high
    base = acc_count;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data = 8'h3C;
    t = 0;
    while (acc_count < base + 1 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    req_data = 8'hC3;
    while (acc_count < base + 2 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_accepts", acc_count, base + 2);
    chk("t5_spacing", acc_cyc - prev_acc_cyc, T + 2);
    wait_done();

    // random writes
    for (int n = 0; n < 24; n++) begin
      send(W'($urandom), ($urandom_range(0, 2) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    stuck = '0;

    // test 6: SETUP=3, PULSE=1, HOLD=4 on the second instance
    @(posedge clk); #1;
    b_valid = 1'b1;
    b_data = 8'h5A;
    @(negedge clk);
    chk("t6_ready", b_ready, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    b_data = 8'h00;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      chk("t6_d", b_d, 8'h5A);
      chk("t6_en", b_en, (k == 3) ? 1 : 0);
      chk("t6_done", b_done, (k == 8) ? 1 : 0);
      chk("t6_err", b_err, 0);
      chk("t6_ready_seq", b_ready, (k == 9) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
